serial_subtractor_16bit: RTL and testbench
==========================================

# serial_subtractor_16bit

Bit-serial two's-complement subtractor. It computes diff = a − b − bin one bit per clock, LSB first, through a single registered borrow. It is the area-minimal subtraction counterpart to the parallel ripple-carry adder in the arithmetics library. Operands arrive and results leave over valid/ready handshakes, so the block can sit behind a sequencer or ALU front end that tolerates multi-cycle latency.

## Interface
- WIDTH, 16, operand/result width in bits; legal range is WIDTH ≥ 2.
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset; asynchronous assert, active-low.
- in_valid  input  1  operands a, b, bin are valid.
- in_ready  output  1  block can accept an operation.
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- bin  input  1  borrow-in.
- out_valid  output  1  diff/bout (and overflow) are valid.
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a − b − bin, modulo 2^WIDTH.
- bout  output  1  borrow-out; 1 when a < b + bin as unsigned values.
- overflow  output  1  signed overflow; present only with SERIAL_SUB_OVERFLOW_EN.

## Operation
- FSM states are IDLE, RUN and DONE.
- **IDLE**
  - in_ready=1, out_valid=0.
  - When in_valid && in_ready: latch a and b into shift registers, set borrow_q=bin, clear the bit counter, go to RUN.
- **RUN**
  - in_ready=0, out_valid=0. Inputs are ignored.
  - Each cycle, with x = a_sr[0], y = b_sr[0]:
    - d = x ^ y ^ borrow_q
    - borrow_q ← (~x & y) | (~(x ^ y) & borrow_q)
    - d shifts into the result register at the MSB.
    - a_sr and b_sr shift right. The counter increments.
  - On the cycle the counter equals WIDTH−1, go to DONE after the update.
  - The result register then holds diff LSB-aligned, and bout = borrow_q.
- **DONE**
  - out_valid=1, in_ready=0. diff, bout and overflow are held stable.
  - When out_ready=1, go to IDLE.
- diff and bout are registered. They keep their last value until the next RUN overwrites the result register.
- The counter is $clog2(WIDTH) bits wide. The counter never wraps, because the FSM leaves RUN at WIDTH−1.

## Timing
- Reset values: in_ready=0 while rst_n=0 and 1 after release (FSM in IDLE); out_valid=0, diff=0, bout=0, overflow=0.
- Latency: the accept edge is edge 0. out_valid rises after edge WIDTH, i.e. 16 cycles for the default width.
- Throughput with out_ready held at 1:
  - The result handshake completes at edge WIDTH+1, and in_ready is 1 in the following cycle.
  - The earliest next accept is edge WIDTH+2. Issue interval = WIDTH+2 cycles.
- Backpressure: while out_valid=1 and out_ready=0, all outputs stay constant indefinitely. in_valid is ignored.
- Simultaneous events:
  - in_valid during RUN or DONE has no effect.
  - No input/output overlap exists, so in_ready and out_valid are never both 1.
- Reset mid-operation: any state returns to IDLE immediately. The operation is discarded and all outputs take their reset values.

## Configuration
- Macro: SERIAL_SUB_OVERFLOW_EN.
- **Defined**
  - The overflow port exists. The block latches a[WIDTH−1] and b[WIDTH−1] at accept.
  - In DONE: overflow = (a_msb ^ b_msb) & (a_msb ^ diff[WIDTH−1]).
  - overflow is registered, valid with out_valid, and reset to 0.
- **Undefined**
  - No overflow port and no MSB capture registers. All other behaviour is identical.

## Structure
- Shared package serial_arith_pkg holds:
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2) as localparams;
  - the default width constant SERIAL_DEFAULT_WIDTH=16.
- One sub-module, full_subtractor:
  - combinational 1-bit cell (x, y, bin → d, bout);
  - the borrow-chain counterpart of the full adder cell;
  - instantiated once and reused every cycle.

## Test plan
- a=16'h0005, b=16'h0003, bin=0 → diff=16'h0002, bout=0; out_valid rises exactly 16 cycles after the accept edge.
- a=16'h0000, b=16'h0001, bin=0 → diff=16'hFFFF, bout=1.
- a=16'h1234, b=16'h1234, bin=1 → diff=16'hFFFF, bout=1.
- With SERIAL_SUB_OVERFLOW_EN defined, a=16'h8000, b=16'h0001 → diff=16'h7FFF, bout=0, overflow=1. a=16'h0003, b=16'h0001 → overflow=0.
- Backpressure case:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid rises, toggling in_valid with new operands.
  - Response: diff and bout stay stable, in_ready stays 0, and no new operation starts.
  - Then release out_ready: the block returns to IDLE and the next operation computes correctly.
- Reset case:
  - Stimulus: assert rst_n=0 during RUN at bit 8.
  - Response: out_valid=0, diff=0 and bout=0 immediately; in_ready=1 after release.
  - A fresh a=16'h0100, b=16'h0001 then yields diff=16'h00FF, bout=0.

Source files
------------

// File: rtl/serial_arith_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_arith_pkg
// Description : Shared constants and FSM encoding for bit-serial arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_arith_pkg;

  localparam int SERIAL_DEFAULT_WIDTH = 16;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_RUN  = RUN,
    ST_DONE = DONE
  } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_subtractor_16bit_if.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_16bit_if
// Description : Operand/result handshake bundle for the serial subtractor.
//               overflow exists only with SERIAL_SUB_OVERFLOW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
interface serial_subtractor_16bit_if
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_DEFAULT_WIDTH
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SERIAL_SUB_OVERFLOW_EN
  logic             overflow;
`endif

  modport master (
    output in_valid, a, b, bin, out_ready,
`ifdef SERIAL_SUB_OVERFLOW_EN
    input  overflow,
`endif
    input  in_ready, out_valid, diff, bout
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
`ifdef SERIAL_SUB_OVERFLOW_EN
    output overflow,
`endif
    output in_ready, out_valid, diff, bout
  );
endinterface
`default_nettype wire

// File: rtl/full_subtractor.sv
`default_nettype none
// ============================================================================
// Module      : full_subtractor
// Description : Combinational 1-bit subtractor cell, d = x - y - bin.
// Revision    : 1.0 - initial release
// ============================================================================
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);
  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule
`default_nettype wire

// File: rtl/serial_subtractor_16bit.sv
`default_nettype none
// ============================================================================
// Module      : serial_subtractor_16bit
// Description : Bit-serial a - b - bin, LSB first, one bit per clock.
//               Optional signed overflow output with SERIAL_SUB_OVERFLOW_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor_16bit
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = SERIAL_DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  serial_subtractor_16bit_if.slave bus
);
  localparam int              CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_a_sr;
  logic [WIDTH-1:0] r_b_sr;
  logic [WIDTH-1:0] r_res;
  logic             r_borrow;
  logic             r_bout;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_bout;
  logic             w_accept;
  logic             w_last;

  full_subtractor u_cell (
    .x    (r_a_sr[0]),
    .y    (r_b_sr[0]),
    .bin  (r_borrow),
    .d    (w_d),
    .bout (w_bout)
  );

  assign w_accept = (r_state == ST_IDLE) && bus.in_valid;
  assign w_last   = (r_state == ST_RUN) && (r_cnt == C_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (bus.in_valid)  w_next = ST_RUN;
      ST_RUN:  if (w_last)        w_next = ST_DONE;
      ST_DONE: if (bus.out_ready) w_next = ST_IDLE;
      default:                    w_next = ST_IDLE;
    endcase
  end

  // Datapath: the counter stops at WIDTH-1 rather than wrapping on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_res    <= '0;
      r_borrow <= 1'b0;
      r_bout   <= 1'b0;
      r_cnt    <= '0;
    end else if (w_accept) begin
      r_a_sr   <= bus.a;
      r_b_sr   <= bus.b;
      r_borrow <= bus.bin;
      r_cnt    <= '0;
    end else if (r_state == ST_RUN) begin
      r_a_sr   <= {1'b0, r_a_sr[WIDTH-1:1]};
      r_b_sr   <= {1'b0, r_b_sr[WIDTH-1:1]};
      r_res    <= {w_d, r_res[WIDTH-1:1]};
      r_borrow <= w_bout;
      if (w_last) begin
        r_bout <= w_bout;
      end else begin
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

`ifdef SERIAL_SUB_OVERFLOW_EN
  logic r_a_msb;
  logic r_b_msb;
  logic r_ovf;

  // On the last RUN cycle w_d is the result MSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_msb <= 1'b0;
      r_b_msb <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a_msb <= bus.a[WIDTH-1];
      r_b_msb <= bus.b[WIDTH-1];
    end else if (w_last) begin
      r_ovf   <= (r_a_msb ^ r_b_msb) & (r_a_msb ^ w_d);
    end
  end

  assign bus.overflow = r_ovf;
`endif

  assign bus.in_ready  = rst_n && (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.diff      = r_res;
  assign bus.bout      = r_bout;
endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_16bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_subtractor_16bit
// Description : Scoreboard bench for serial_subtractor_16bit (directed vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_16bit;
  import serial_arith_pkg::*;

  typedef struct {
    logic [15:0] diff;
    logic        bout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  logic r_prev_ov;
  exp_t sb[$];

  serial_subtractor_16bit_if #(.WIDTH(16)) bus ();

  serial_subtractor_16bit #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard on each result handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && !r_prev_ov && sb.size() != 0)
        check("latency", 32'(cyc - sb[0].acc), 32'd16);
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("diff", 32'(bus.diff), 32'(e.diff));
          check("bout", 32'(bus.bout), 32'(e.bout));
`ifdef SERIAL_SUB_OVERFLOW_EN
          check("overflow", 32'(bus.overflow), 32'(e.ovf));
`endif
        end
      end
    end
    r_prev_ov <= rst_n ? bus.out_valid : 1'b0;
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (bus.in_ready !== 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (bus.in_ready !== 1'b1) check("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic bin,
                      input logic [15:0] ed, input logic eb, input logic eo);
    exp_t e;
    wait_ready();
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    e.diff = ed; e.bout = eb; e.ovf = eo; e.acc = cyc;
    sb.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    total = 0; bad = 0; r_prev_ov = 1'b0;
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.bin = 1'b0; bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_diff", 32'(bus.diff), 32'd0);
    check("rst_bout", 32'(bus.bout), 32'd0);
`ifdef SERIAL_SUB_OVERFLOW_EN
    check("rst_overflow", 32'(bus.overflow), 32'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("idle_in_ready", 32'(bus.in_ready), 32'd1);

    send(16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0);
    send(16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    send(16'h1234, 16'h1234, 1'b1, 16'hFFFF, 1'b1, 1'b0);
    send(16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
    send(16'h0003, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
    send(16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
    send(16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Backpressure: result must hold while new operands are offered.
    wait_ready();
    bus.out_ready = 1'b0;
    send(16'hA5A5, 16'h5A5A, 1'b0, 16'h4B4B, 1'b0, 1'b1);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check("bp_out_valid_rise", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = ~bus.in_valid;
      bus.a = 16'(i * 16'h1111);
      bus.b = 16'(i + 1);
      @(posedge clk); #1;
      check("bp_in_ready", 32'(bus.in_ready), 32'd0);
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_diff", 32'(bus.diff), 32'h4B4B);
      check("bp_bout", 32'(bus.bout), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_idle", 32'(bus.in_ready), 32'd1);
    send(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0);

    // Reset at bit 8 of a run discards the operation.
    send(16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    void'(sb.pop_back());
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_diff", 32'(bus.diff), 32'd0);
    check("mid_rst_bout", 32'(bus.bout), 32'd0);
    check("mid_rst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
    send(16'h0100, 16'h0001, 1'b0, 16'h00FF, 1'b0, 1'b0);

    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
